scan_index_sequencer: RTL

- Upstream driver for decoder_generic: produces the binary index `w` and enable `en` that the decoder turns into a one-hot select `y`.
- Steps through indices 0..last_idx, skipping masked indices.
- Holds each index for a programmable dwell time, with a one-cycle blanking gap between indices to avoid select overlap.
- Runs once (single-pass) or continuously; used for display-digit or bank scanning.

---
 rtl/scan_pkg.sv | 17 +
 rtl/scan_next_index.sv | 34 +++
 rtl/scan_index_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan index sequencer.
//   scan_state_e : sequencer state encoding
//   SCAN_N       : default index width (must match the decoder's n)
//   SCAN_DWELL_W : default width of the dwell-time field
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } scan_state_e;

  localparam int unsigned SCAN_N       = 4;
  localparam int unsigned SCAN_DWELL_W = 8;

endpackage

// File: rtl/scan_next_index.sv
// Combinational search for the lowest unmasked index in a window.
//   cur        : current index; search starts above it unless from_start
//   last       : highest index that may be returned
//   mask       : bit i = 1 excludes index i
//   from_start : 1 = search from index 0 inclusive
//   idx        : lowest qualifying index (0 when none)
//   valid      : a qualifying index exists
module scan_next_index #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      cur,
  input  logic [N-1:0]      last,
  input  logic [2**N-1:0]   mask,
  input  logic              from_start,
  output logic [N-1:0]      idx,
  output logic              valid
);

  localparam int unsigned NUM = 32'd1 << N;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Ascending scan; the first hit latches valid so later hits are ignored.
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!valid && !mask[i] && (N'(i) <= last) &&
          (from_start || (N'(i) > cur))) begin
        idx   = N'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: drives index w and enable en into a one-hot
// decoder, stepping through unmasked indices 0..last_idx with a
// programmable dwell and a one-cycle blanking gap between indices.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (IDLE only); stop : abort from any state
//   cont       : 1 = wrap continuously, 0 = single pass
//   dwell      : ACTIVE cycles per index minus 1
//   last_idx   : highest index scanned; mask : bit i = 1 skips index i
//   w, en      : registered decoder index / enable
//   busy       : scan in progress; done : single-pass completion pulse
module scan_index_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned N       = SCAN_N,
  parameter int unsigned DWELL_W = SCAN_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N-1:0]       last_idx,
  input  logic [2**N-1:0]    mask,
  output logic [N-1:0]       w,
  output logic               en,
  output logic               busy,
  output logic               done
);

  scan_state_e        state_q, state_d;
  logic [N-1:0]       w_q, w_d, pend_q, pend_d;
  logic               en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [N-1:0]       last_q, last_d;
  logic [2**N-1:0]    mask_q, mask_d;
  logic               cont_q, cont_d;

  logic               idle;
  logic [N-1:0]       first_idx, next_idx;
  logic               first_valid, next_valid;

  assign idle = (state_q == S_IDLE);

  // In IDLE the first index comes from the live inputs, since the shadow
  // registers are loaded on the same edge; afterwards it is the wrap target.
  scan_next_index #(.N(N)) u_first (
    .cur        ('0),
    .last       (idle ? last_idx : last_q),
    .mask       (idle ? mask : mask_q),
    .from_start (1'b1),
    .idx        (first_idx),
    .valid      (first_valid)
  );

  scan_next_index #(.N(N)) u_next (
    .cur        (w_q),
    .last       (last_q),
    .mask       (mask_q),
    .from_start (1'b0),
    .idx        (next_idx),
    .valid      (next_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      pend_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pend_d  = pend_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    last_d  = last_q;
    mask_d  = mask_q;
    cont_d  = cont_q;

    case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        w_d    = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          dwell_d = dwell;
          last_d  = last_idx;
          mask_d  = mask;
          cont_d  = cont;
          busy_d  = 1'b1;
          cnt_d   = '0;
          if (first_valid) begin
            state_d = S_ACTIVE;
            w_d     = first_idx;
            en_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (cnt_q == dwell_q) begin
          en_d = 1'b0;
          if (next_valid) begin
            state_d = S_GAP;
            pend_d  = next_idx;
          end else if (cont_q) begin
            state_d = S_GAP;
            pend_d  = first_idx;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_ACTIVE;
        w_d     = pend_q;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        w_d     = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        w_d     = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (stop && !idle) begin
      state_d = S_IDLE;
      w_d     = '0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign w    = w_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
